// File: rtl/rf_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler.
package rf_write_scheduler_pkg;

  // Scheduler operating mode: clearing the register file, then normal writes.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Register address width and the hardwired-zero register.
  localparam int              REG_AW   = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/rr_arbiter_3.sv
// Three-way round-robin arbiter: one-hot grant, pointer advances past the winner.
module rr_arbiter_3 #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      ptr
);

  // Pick the first requester at or after the pointer, wrapping 2 -> 0.
  always_comb begin
    grant = '0;
    case (ptr)
      2'd1: begin
        if (req[1])      grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      2'd2: begin
        if (req[2])      grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if (req[0])      grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

  // Move priority to the index after the granted requester on a real transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 2'd0;
    end else if (advance) begin
      if (grant[0])      ptr <= 2'd1;
      else if (grant[1]) ptr <= 2'd2;
      else               ptr <= 2'd0;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write scheduler: clears r1..r31 after reset, then arbitrates
// three write requesters onto a single registered write port and tracks a
// pending-write scoreboard.
module rf_write_scheduler
  import rf_write_scheduler_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NREQ = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*REG_AW-1:0] req_rd,
  input  logic [NREQ*XLEN-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   resv_valid,
  input  logic [REG_AW-1:0]      resv_rd,
  output logic [NREG-1:0]        busy,
  output logic                   RegWrite,
  output logic [REG_AW-1:0]      Rd,
  output logic [XLEN-1:0]        Write_data,
  output logic                   init_done
);

  localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NREG - 1);

  state_t              state;
  logic [REG_AW-1:0]   init_cnt;
  logic                init_done_p1;
  logic                vld_p1;
  logic [REG_AW-1:0]   rd_p1;
  logic [XLEN-1:0]     wdata_p1;
  logic [NREG-1:0]     busy_q;
  logic [NREG-1:0]     busy_nxt;
  logic [NREQ-1:0]     arb_req;
  logic [NREQ-1:0]     grant;
  logic [1:0]          unused_arb_ptr;
  logic                xfer_p0;
  logic [REG_AW-1:0]   xfer_rd_p0;
  logic [XLEN-1:0]     xfer_data_p0;

  // Requests are invisible to the arbiter until the clear sequence has handed over.
  assign arb_req   = (state == RUN) ? req_valid : '0;
  assign req_ready = grant;
  assign xfer_p0   = |grant;

  rr_arbiter_3 #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (xfer_p0),
    .grant   (grant),
    .ptr     (unused_arb_ptr)
  );

  // Select the destination and data of the granted requester.
  always_comb begin
    xfer_rd_p0   = '0;
    xfer_data_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        xfer_rd_p0   = req_rd[i*REG_AW +: REG_AW];
        xfer_data_p0 = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // ---- stage p0 -> p1: mode control and registered write port ----
  // Sequence INIT clears, then forward granted writes one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= INIT;
      init_cnt     <= REG_AW'(1);
      init_done_p1 <= 1'b0;
      vld_p1       <= 1'b0;
      rd_p1        <= '0;
      wdata_p1     <= '0;
    end else begin
      case (state)
        INIT: begin
          vld_p1   <= 1'b1;
          rd_p1    <= init_cnt;
          wdata_p1 <= '0;
          if (init_cnt == LAST_REG) begin
            state <= RUN;
          end else begin
            init_cnt <= init_cnt + REG_AW'(1);
          end
        end
        RUN: begin
          init_done_p1 <= 1'b1;
          // A write to r0 still consumes the grant but never reaches the file.
          vld_p1       <= xfer_p0 && (xfer_rd_p0 != ZERO_REG);
          if (xfer_p0) begin
            rd_p1    <= xfer_rd_p0;
            wdata_p1 <= xfer_data_p0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Scoreboard update: completion clears, then a reservation to the same register wins.
  always_comb begin
    busy_nxt = busy_q;
    if (xfer_p0) begin
      busy_nxt[xfer_rd_p0] = 1'b0;
    end
    if (resv_valid) begin
      busy_nxt[resv_rd] = 1'b1;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // Scoreboard register; reservations are ignored while clearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else if (state == RUN) begin
      busy_q <= busy_nxt;
    end
  end

  assign busy       = busy_q;
  assign RegWrite   = vld_p1;
  assign Rd         = rd_p1;
  assign Write_data = wdata_p1;
  assign init_done  = init_done_p1;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: directed steps plus a random
// phase, compared against a round-robin / scoreboard reference model.
module tb_rf_write_scheduler;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        resv_valid;
  logic [4:0]  resv_rd;
  logic [31:0] busy;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic        init_done;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ptr;
  logic [31:0] m_busy;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_known;

  rf_write_scheduler #(
    .XLEN (32),
    .NREG (32),
    .NREQ (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resv_valid (resv_valid),
    .resv_rd    (resv_rd),
    .busy       (busy),
    .RegWrite   (RegWrite),
    .Rd         (Rd),
    .Write_data (Write_data),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_rd     = '0;
    req_data   = '0;
    resv_valid = 1'b0;
    resv_rd    = '0;
  endtask

  task automatic model_after_init();
    m_ptr   = 0;
    m_busy  = '0;
    m_rd    = 5'd31;
    m_data  = '0;
    m_known = 1'b1;
  endtask

  // Assert reset away from the edge, hold it across two edges, release.
  task automatic apply_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_rst_regwrite"}, 32'(RegWrite), 32'd0);
    chk({tag, "_rst_rd"}, 32'(Rd), 32'd0);
    chk({tag, "_rst_data"}, Write_data, 32'd0);
    chk({tag, "_rst_initdone"}, 32'(init_done), 32'd0);
    chk({tag, "_rst_busy"}, busy, 32'd0);
    chk({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_rsthold_regwrite"}, 32'(RegWrite), 32'd0);
    chk({tag, "_rsthold_rd"}, 32'(Rd), 32'd0);
    chk({tag, "_rsthold_busy"}, busy, 32'd0);
    idle_inputs();
    reset = 1'b1;
  endtask

  // Clear-sequence cycles with noisy requests and reservations that must be ignored.
  task automatic init_seq(input int ncycles);
    for (int k = 1; k <= ncycles; k++) begin
      req_valid  = 3'b111;
      req_rd     = 15'($urandom);
      req_data   = {$urandom, $urandom, $urandom};
      resv_valid = 1'b1;
      resv_rd    = 5'($urandom_range(1, 31));
      #1;
      chk("init_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      if (k == 31) idle_inputs();
      chk("init_regwrite", 32'(RegWrite), 32'd1);
      chk("init_rd", 32'(Rd), 32'(k));
      chk("init_data", Write_data, 32'd0);
      chk("init_done_low", 32'(init_done), 32'd0);
      chk("init_busy", busy, 32'd0);
    end
  endtask

  // One RUN cycle: apply inputs, check grant, clock, check write port and scoreboard.
  task automatic run_cycle(input string tag, input logic [2:0] v, input logic [14:0] rds,
                           input logic [95:0] dat, input logic rv, input logic [4:0] rrd);
    int          g;
    int          idx;
    logic [2:0]  er;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    req_valid  = v;
    req_rd     = rds;
    req_data   = dat;
    resv_valid = rv;
    resv_rd    = rrd;
    g = -1;
    for (int off = 0; off < 3; off++) begin
      idx = (m_ptr + off) % 3;
      if (g < 0 && v[idx]) g = idx;
    end
    er = '0;
    wrd = '0;
    wdat = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      wrd   = rds[g*5 +: 5];
      wdat  = dat[g*32 +: 32];
    end
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(er));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_ptr = (g + 1) % 3;
      if (wrd != 5'd0) begin
        m_rd    = wrd;
        m_data  = wdat;
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
      if (wrd != 5'd0) m_busy[wrd] = 1'b0;
    end
    if (rv && rrd != 5'd0) m_busy[rrd] = 1'b1;
    chk({tag, "_regwrite"}, 32'(RegWrite), 32'((g >= 0) && (wrd != 5'd0)));
    if (m_known) begin
      chk({tag, "_rd"}, 32'(Rd), 32'(m_rd));
      chk({tag, "_data"}, Write_data, m_data);
    end
    chk({tag, "_busy"}, busy, m_busy);
    chk({tag, "_initdone"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;

    // Power-on reset and full clear sequence
    apply_reset("por");
    init_seq(31);
    model_after_init();
    run_cycle("first_run_idle", 3'b000, '0, '0, 1'b0, 5'd0);

    // All three requesters continuously valid: grants rotate 0,1,2,0,1,2
    for (int n = 0; n < 6; n++) begin
      run_cycle("rr_all", 3'b111, {5'd7, 5'd6, 5'd5},
                {32'hC0000000 + 32'(n), 32'hB0000000 + 32'(n), 32'hA0000000 + 32'(n)},
                1'b0, 5'd0);
    end
    run_cycle("hold_after_idle", 3'b000, '0, '0, 1'b0, 5'd0);
    run_cycle("hold_after_idle2", 3'b000, '0, '0, 1'b0, 5'd0);

    // Write to r0: handshake happens, no register-file write
    run_cycle("rd0_write", 3'b010, {5'd3, 5'd0, 5'd2}, {32'h1, 32'hDEADBEEF, 32'h2}, 1'b0, 5'd0);
    run_cycle("rd0_after", 3'b000, '0, '0, 1'b0, 5'd0);

    // Reserve r9, write it two cycles later
    run_cycle("resv9", 3'b000, '0, '0, 1'b1, 5'd9);
    chk("resv9_bit_a", 32'(busy[9]), 32'd1);
    run_cycle("resv9_wait", 3'b000, '0, '0, 1'b0, 5'd0);
    chk("resv9_bit_b", 32'(busy[9]), 32'd1);
    run_cycle("resv9_write", 3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 1'b0, 5'd0);
    chk("resv9_cleared", 32'(busy[9]), 32'd0);

    // Reservation and completion to r9 in the same cycle: reservation wins
    run_cycle("resv9_same", 3'b100, {5'd9, 5'd0, 5'd0}, {32'h98, 32'h0, 32'h0}, 1'b1, 5'd9);
    chk("resv9_same_bit", 32'(busy[9]), 32'd1);
    run_cycle("resv9_clear", 3'b100, {5'd9, 5'd0, 5'd0}, {32'h97, 32'h0, 32'h0}, 1'b0, 5'd0);

    // r0 is never reserved; write to a non-busy register leaves it clear
    run_cycle("resv0", 3'b000, '0, '0, 1'b1, 5'd0);
    run_cycle("write_free", 3'b001, {5'd0, 5'd0, 5'd12}, {32'h0, 32'h0, 32'h12}, 1'b0, 5'd0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      run_cycle("rand", 3'($urandom), 15'($urandom), {$urandom, $urandom, $urandom},
                ($urandom_range(0, 3) == 0), 5'($urandom));
    end

    // Reset in RUN while requester 0 is being granted
    req_valid  = 3'b001;
    req_rd     = {5'd0, 5'd0, 5'd20};
    req_data   = {32'h0, 32'h0, 32'h20202020};
    resv_valid = 1'b1;
    resv_rd    = 5'd21;
    #1;
    chk("run_rst_pre_ready", 32'(req_ready), 32'h1);
    apply_reset("run");
    @(posedge clk);
    #1;
    chk("run_rst_restart_regwrite", 32'(RegWrite), 32'd1);
    chk("run_rst_restart_rd", 32'(Rd), 32'd1);
    chk("run_rst_restart_busy", busy, 32'd0);
    // Remaining 9 clear cycles (Rd=2..10) then abort with reset
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk);
      #1;
      chk("init_abort_rd", 32'(Rd), 32'(k));
    end
    apply_reset("init");
    init_seq(31);
    model_after_init();
    run_cycle("post_rst_idle", 3'b000, '0, '0, 1'b0, 5'd0);
    // Pointer back to requester 0
    run_cycle("post_rst_ptr", 3'b111, {5'd7, 5'd6, 5'd5}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0);
    run_cycle("post_rst_ptr2", 3'b111, {5'd7, 5'd6, 5'd5}, {32'h6, 32'h5, 32'h4}, 1'b0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 Parameter XLEN, default 32, data width of the register-file write port.
REQ-002 Parameter NREG, default 32, number of architectural registers; address width is 5.
REQ-003 Parameter NREQ, default 3, number of write requesters, fixed at 3.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NREQ  per-requester write request.
REQ-007 req_rd  in  NREQ*5  per-requester destination register.
REQ-008 req_data  in  NREQ*XLEN  per-requester write data.
REQ-009 req_ready  out  NREQ  per-requester grant; a transfer occurs when valid and ready are both high.
REQ-010 resv_valid  in  1  reserve a destination register for an in-flight operation.
REQ-011 resv_rd  in  5  register to reserve.
REQ-012 busy  out  NREG  scoreboard; bit n high while register n has a pending write.
REQ-013 RegWrite  out  1  write enable to the register file.
REQ-014 Rd  out  5  write address to the register file.
REQ-015 Write_data  out  XLEN  write data to the register file.
REQ-016 init_done  out  1  high once the clear sequence has completed.

Function
REQ-017 The FSM has two states: INIT and RUN. It enters INIT on reset.
REQ-018 In INIT, the block drives RegWrite=1, Write_data=0, and Rd=1,2,...,31 on successive cycles, one register per cycle, in 31 cycles total.
REQ-019 After the cycle that writes Rd=31, the FSM moves to RUN and init_done goes high on the next cycle; init_done then stays high until reset.
REQ-020 In INIT, req_ready is held at 0 and resv_valid is ignored.
REQ-021 In RUN, at most one requester is granted per cycle; req_ready is combinational from req_valid and the round-robin pointer.
REQ-022 Arbitration is round-robin. Priority starts at the index after the last granted requester. After reset, the pointer gives requester 0 highest priority.
REQ-023 The pointer advances only on an actual transfer. With no valid request, it holds.
REQ-024 A granted write appears on RegWrite/Rd/Write_data exactly one cycle after the transfer (registered outputs).
REQ-025 A granted write with rd=0 completes the handshake but produces RegWrite=0 for that cycle.
REQ-026 In RUN, RegWrite is 0 in any cycle that follows a cycle with no transfer; Rd and Write_data then hold their previous values.
REQ-027 resv_valid with resv_rd!=0 sets busy[resv_rd] at the next edge. resv_rd=0 never sets a bit, and busy[0] is constant 0.
REQ-028 A transfer to rd clears busy[rd] at the next edge.
REQ-029 If a reservation and a transfer target the same rd in the same cycle, the reservation wins and busy stays 1.
REQ-030 A transfer to a register whose busy bit is 0 is legal; busy stays 0.

Reset
REQ-031 While reset is low, the outputs are: RegWrite=0, Rd=0, Write_data=0, init_done=0, busy=0, req_ready=0. The pointer is 0 and the FSM state is INIT.
REQ-032 When reset is asserted mid-sequence (in INIT or RUN), any clear sequence or pending write is abandoned immediately. After reset is released, the clear sequence restarts from Rd=1.

Structure
REQ-033 A shared package holds the FSM state typedef (INIT, RUN), the register-address width constant (5), and the zero-register index.
REQ-034 One sub-module, rr_arbiter_3, takes a NREQ-bit request vector and an advance strobe, and produces a one-hot grant vector and an internal pointer.
REQ-035 The expected RTL size is 150 to 300 lines.

Verification
REQ-036 Release reset and hold all requests low -> RegWrite=1 with Rd=1..31 and data 0 on 31 consecutive cycles; init_done rises one cycle after Rd=31.
REQ-037 In RUN, hold all three requesters valid continuously (rd=5,6,7) -> grants go 0,1,2,0,1,2; the register-file writes follow one cycle later.
REQ-038 Requester 1 writes rd=0 with data 0xDEADBEEF -> req_ready[1]=1 and RegWrite=0 in the following cycle.
REQ-039 Reserve rd=9, then requester 2 writes rd=9 two cycles later -> busy[9]=1 for 2 cycles, then 0 after the write edge. Repeating with reservation and write to rd=9 in the same cycle -> busy[9] stays 1.
REQ-040 Assert reset at cycle 10 of INIT, hold it for 2 cycles, then release -> outputs are zero during reset, and the clear sequence restarts at Rd=1 and takes the full 31 cycles.
REQ-041 Assert reset in RUN while requester 0 is granted -> no RegWrite appears after reset; busy is cleared; the grant pointer is back to requester 0.
